// File: rtl/mem_ctrl_if.sv
// Request/response bus between the interconnect (master) and mem_ctrl (slave).
interface mem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 4
);
    logic              req_vld;
    logic [3:0]        req_core_id;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_vld;
    logic [3:0]        rsp_core_id;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              rsp_err;
    logic              fifo_full;
    logic              ovf_sticky;

    modport master (
        output req_vld, req_core_id, req_we, req_addr, req_len, req_wdata,
        input  rsp_vld, rsp_core_id, rsp_data, rsp_last, rsp_err, fifo_full, ovf_sticky
    );

    modport slave (
        input  req_vld, req_core_id, req_we, req_addr, req_len, req_wdata,
        output rsp_vld, rsp_core_id, rsp_data, rsp_last, rsp_err, fifo_full, ovf_sticky
    );
endinterface

// File: rtl/mem_ctrl.sv
// Memory-side stage: request FIFO feeding an IDLE/RD/WR engine over an on-chip word array.
// Optional per-word even parity is enabled by defining MEM_CTRL_PARITY_EN.
module mem_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int LEN_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    mem_ctrl_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
`ifdef MEM_CTRL_PARITY_EN
    localparam int MEM_W = DATA_W + 1;

    function automatic logic even_par(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2} state_t;

    state_t state_r, state_nx;

    logic              f_we    [FIFO_DEPTH];
    logic [3:0]        f_core  [FIFO_DEPTH];
    logic [ADDR_W-1:0] f_addr  [FIFO_DEPTH];
    logic [LEN_W-1:0]  f_len   [FIFO_DEPTH];
    logic [DATA_W-1:0] f_wdata [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              ovf_r;

    logic [3:0]        cmd_core_r;
    logic [ADDR_W-1:0] cmd_addr_r;
    logic [DATA_W-1:0] cmd_wdata_r;
    logic [LEN_W-1:0]  left_r;

    logic [MEM_W-1:0]  mem [DEPTH];
    logic [MEM_W-1:0]  rd_word_s, wr_word_s;
    logic              par_err_s;

    logic              rsp_vld_r, rsp_last_r, rsp_err_r;
    logic [3:0]        rsp_core_r;
    logic [DATA_W-1:0] rsp_data_r;

    logic do_rd_s, do_wr_s, last_op_s, dispatch_s, push_s, drop_s;

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_s = bus.req_vld && ((count_r != FULL_CNT) || dispatch_s);
    assign drop_s = bus.req_vld && !push_s;

    // Request FIFO payload storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            f_we[wr_ptr_r]    <= bus.req_we;
            f_core[wr_ptr_r]  <= bus.req_core_id;
            f_addr[wr_ptr_r]  <= bus.req_addr;
            f_len[wr_ptr_r]   <= bus.req_len;
            f_wdata[wr_ptr_r] <= bus.req_wdata;
        end
    end

    // FIFO pointers, occupancy and overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (push_s)     wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (dispatch_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_s, dispatch_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            ovf_r <= ovf_r | drop_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= S_IDLE;
        else        state_r <= state_nx;
    end

    // Per-state actions; the cycle issuing the final array access also dispatches the
    // next request, so consecutive responses run back-to-back.
    always_comb begin
        do_rd_s   = 1'b0;
        do_wr_s   = 1'b0;
        last_op_s = 1'b0;
        case (state_r)
            S_RD: begin
                do_rd_s   = 1'b1;
                last_op_s = (left_r == LEN_W'(1));
            end
            S_WR: begin
                do_wr_s   = 1'b1;
                last_op_s = 1'b1;
            end
            default: begin
                do_rd_s   = 1'b0;
                last_op_s = 1'b0;
            end
        endcase
        dispatch_s = ((state_r == S_IDLE) || last_op_s) && (count_r != {CNT_W{1'b0}});
    end

    // Next-state logic.
    always_comb begin
        state_nx = S_IDLE;
        if (dispatch_s) begin
            state_nx = f_we[rd_ptr_r] ? S_WR : S_RD;
        end else begin
            case (state_r)
                S_RD:    state_nx = last_op_s ? S_IDLE : S_RD;
                S_WR:    state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Active command: address walks forward (wrapping) one word per read beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_core_r  <= 4'd0;
            cmd_addr_r  <= {ADDR_W{1'b0}};
            cmd_wdata_r <= {DATA_W{1'b0}};
            left_r      <= {LEN_W{1'b0}};
        end else if (dispatch_s) begin
            cmd_core_r  <= f_core[rd_ptr_r];
            cmd_addr_r  <= f_addr[rd_ptr_r];
            cmd_wdata_r <= f_wdata[rd_ptr_r];
            left_r      <= (f_len[rd_ptr_r] == {LEN_W{1'b0}}) ? LEN_W'(1) : f_len[rd_ptr_r];
        end else if (do_rd_s) begin
            cmd_addr_r <= cmd_addr_r + ADDR_W'(1);
            left_r     <= left_r - LEN_W'(1);
        end else begin
            left_r <= left_r;
        end
    end

`ifdef MEM_CTRL_PARITY_EN
    assign wr_word_s = {even_par(cmd_wdata_r), cmd_wdata_r};
    assign par_err_s = rd_word_s[DATA_W] != even_par(rd_word_s[DATA_W-1:0]);
`else
    assign wr_word_s = cmd_wdata_r;
    assign par_err_s = 1'b0;
`endif
    assign rd_word_s = mem[cmd_addr_r];

    // Word array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (do_wr_s) mem[cmd_addr_r] <= wr_word_s;
    end

    // Response register doubles as the synchronous read data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_vld_r  <= 1'b0;
            rsp_core_r <= 4'd0;
            rsp_data_r <= {DATA_W{1'b0}};
            rsp_last_r <= 1'b0;
            rsp_err_r  <= 1'b0;
        end else if (do_rd_s) begin
            rsp_vld_r  <= 1'b1;
            rsp_core_r <= cmd_core_r;
            rsp_data_r <= rd_word_s[DATA_W-1:0];
            rsp_last_r <= last_op_s;
            rsp_err_r  <= par_err_s;
        end else if (do_wr_s) begin
            rsp_vld_r  <= 1'b1;
            rsp_core_r <= cmd_core_r;
            rsp_data_r <= {DATA_W{1'b0}};
            rsp_last_r <= 1'b1;
            rsp_err_r  <= 1'b0;
        end else begin
            rsp_vld_r  <= 1'b0;
            rsp_core_r <= 4'd0;
            rsp_data_r <= {DATA_W{1'b0}};
            rsp_last_r <= 1'b0;
            rsp_err_r  <= 1'b0;
        end
    end

    assign bus.rsp_vld     = rsp_vld_r;
    assign bus.rsp_core_id = rsp_core_r;
    assign bus.rsp_data    = rsp_data_r;
    assign bus.rsp_last    = rsp_last_r;
    assign bus.rsp_err     = rsp_err_r;
    assign bus.fifo_full   = (count_r == FULL_CNT);
    assign bus.ovf_sticky  = ovf_r;
endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: transaction-level model predicts every response beat.
module tb_mem_ctrl;
    typedef struct packed {
        logic [3:0]  core;
        logic [31:0] data;
        logic        last;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    logic [31:0] mem_m [1024];
    rsp_t        exp_q [$];
    int          rsp_cyc_q [$];
    rsp_t        e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_ctrl_if #(.DATA_W(32), .ADDR_W(10), .LEN_W(4)) bus ();

    mem_ctrl #(.DATA_W(32), .ADDR_W(10), .LEN_W(4), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request cycle; if accepted, apply it to the model in arrival order.
    task automatic send(input logic we, input logic [3:0] core, input logic [9:0] addr,
                        input logic [3:0] len, input logic [31:0] wd, input bit accepted);
        int n;
        logic [9:0] a;
        bus.req_vld = 1'b1; bus.req_we = we; bus.req_core_id = core;
        bus.req_addr = addr; bus.req_len = len; bus.req_wdata = wd;
        if (accepted) begin
            if (we) begin
                mem_m[addr] = wd;
                exp_q.push_back('{core, 32'h0, 1'b1, 1'b0});
            end else begin
                n = (len == 4'd0) ? 1 : int'(len);
                for (int k = 0; k < n; k++) begin
                    a = addr + 10'(k);
                    exp_q.push_back('{core, mem_m[a], (k == n - 1), 1'b0});
                end
            end
        end
        tick();
        bus.req_vld = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 3000) begin
            tick();
            b++;
        end
        chk_eq("drain_left", exp_q.size(), 0);
        exp_q.delete();
        tick();
        tick();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk_eq({tag, "_vld"}, bus.rsp_vld, 0);
        chk_eq({tag, "_bus"}, {bus.rsp_core_id, bus.rsp_data, bus.rsp_last, bus.rsp_err}, 0);
        chk_eq({tag, "_full"}, bus.fifo_full, 0);
        chk_eq({tag, "_ovf"}, bus.ovf_sticky, 0);
    endtask

    // Response monitor: every beat must match the head of the model's queue.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.rsp_vld) begin
                rsp_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk_eq("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk_eq("rsp_core", bus.rsp_core_id, e.core);
                    chk_eq("rsp_data", bus.rsp_data, e.data);
                    chk_eq("rsp_last", bus.rsp_last, e.last);
                    chk_eq("rsp_err", bus.rsp_err, e.err);
                end
            end else begin
                chk_eq("idle_zero", {bus.rsp_core_id, bus.rsp_data, bus.rsp_last, bus.rsp_err}, 0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int t0;
        int w;
        logic [9:0] a;
        bus.req_vld = 1'b0; bus.req_we = 1'b0; bus.req_core_id = 4'd0;
        bus.req_addr = 10'd0; bus.req_len = 4'd0; bus.req_wdata = 32'd0;
        repeat (3) tick();
        chk_outputs_zero("reset");
        reset = 1'b1;
        tick();

        // Give every word a known value.
        for (int i = 0; i < 1024; i++) send(1'b1, 4'(i % 4), 10'(i), 4'd0, $urandom, 1'b1);
        drain();

        // Write then read of the same word, back-to-back.
        rsp_cyc_q.delete();
        t0 = cyc;
        send(1'b1, 4'd2, 10'h005, 4'd0, 32'hDEADBEEF, 1'b1);
        send(1'b0, 4'd1, 10'h005, 4'd1, 32'd0, 1'b1);
        drain();
        chk_eq("raw_nbeats", rsp_cyc_q.size(), 2);
        chk_eq("raw_ack_cyc", rsp_cyc_q[0], t0 + 3);
        chk_eq("raw_rd_cyc", rsp_cyc_q[1], t0 + 4);

        // Burst across the top of the address space.
        for (int i = 0; i < 4; i++) send(1'b1, 4'd0, 10'(10'h3FE + 10'(i)), 4'd0, 32'(i + 1), 1'b1);
        drain();
        rsp_cyc_q.delete();
        send(1'b0, 4'd3, 10'h3FE, 4'd4, 32'd0, 1'b1);
        drain();
        chk_eq("wrap_nbeats", rsp_cyc_q.size(), 4);
        chk_eq("wrap_contig", rsp_cyc_q[3] - rsp_cyc_q[0], 3);

        // Zero length reads as a single beat.
        rsp_cyc_q.delete();
        send(1'b0, 4'd0, 10'h2A0, 4'd0, 32'd0, 1'b1);
        drain();
        chk_eq("len0_nbeats", rsp_cyc_q.size(), 1);

        // Random mixed traffic, paced so nothing is dropped.
        for (int i = 0; i < 300; i++) begin
            w = 0;
            while (bus.fifo_full && w < 64) begin
                tick();
                w++;
            end
            a = 10'h3F0 + 10'($urandom_range(0, 31));
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), a,
                 4'($urandom_range(0, 15)), $urandom, 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        chk_eq("rand_no_ovf", bus.ovf_sticky, 0);

`ifdef MEM_CTRL_PARITY_EN
        send(1'b1, 4'd0, 10'h020, 4'd0, 32'h1, 1'b1);
        send(1'b1, 4'd0, 10'h021, 4'd0, 32'h1, 1'b1);
        drain();
        dut.mem[10'h020][32] = ~dut.mem[10'h020][32];
        send(1'b0, 4'd0, 10'h020, 4'd1, 32'd0, 1'b1);
        exp_q[exp_q.size() - 1].err = 1'b1;
        send(1'b0, 4'd0, 10'h021, 4'd1, 32'd0, 1'b1);
        drain();
`endif

        // Overflow: long read holds the engine while five writes arrive.
        send(1'b0, 4'd1, 10'h200, 4'd8, 32'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                chk_eq("ovf_full", bus.fifo_full, 1);
                chk_eq("ovf_pre", bus.ovf_sticky, 0);
            end
            send(1'b1, 4'(i % 4), 10'(10'h100 + 10'(i)), 4'd0, 32'hA5A50000 + 32'(i), (i < 4));
        end
        chk_eq("ovf_set", bus.ovf_sticky, 1);
        drain();
        for (int i = 0; i < 5; i++) send(1'b0, 4'd2, 10'(10'h100 + 10'(i)), 4'd1, 32'd0, 1'b1);
        drain();
        chk_eq("ovf_hold", bus.ovf_sticky, 1);

        // Reset in the middle of a burst with more work queued behind it.
        send(1'b0, 4'd2, 10'h010, 4'd15, 32'd0, 1'b1);
        send(1'b0, 4'd3, 10'h030, 4'd3, 32'd0, 1'b1);
        repeat (5) tick();
        reset = 1'b0;
        @(negedge clk);
        chk_outputs_zero("midrst");
        exp_q.delete();
        rsp_cyc_q.delete();
        tick();
        reset = 1'b1;
        repeat (30) tick();
        chk_eq("no_stale", rsp_cyc_q.size(), 0);
        chk_eq("post_rst_ovf", bus.ovf_sticky, 0);
        send(1'b0, 4'd1, 10'h3FF, 4'd2, 32'd0, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
